// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - mode encodings and index-width helper for arb_mux_reg
package arb_mux_pkg;

  localparam logic [1:0] MODE_SEL   = 2'b00;
  localparam logic [1:0] MODE_FIXED = 2'b01;
  localparam logic [1:0] MODE_RR    = 2'b10;

  // Index width; kept at least 1 so a degenerate count never yields a zero-width port
  function automatic int sel_w_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_mux_pick.sv
// rtl/arb_mux_pick.sv - combinational rotating-priority picker (first request at or above start, wrapping)
module arb_mux_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = SW'(j);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - N:1 arbitrating mux with registered output; ARB_MUX_RR_EN enables round-robin mode
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = sel_w_f(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic              sel_err_q, sel_err_d;
  logic              load_en, sel_ok, xfer;
  logic [SEL_W-1:0]  pick_start, pick_idx, gnt_idx;
  logic [NUM_IN-1:0] pick_gnt, gnt;
  logic              pick_any, gnt_any;

  assign load_en = !out_valid_q || out_ready;
  assign sel_ok  = (32'(sel) < 32'(NUM_IN));

`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  assign pick_start = (mode == MODE_RR) ? rr_ptr_q : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && mode == MODE_RR)
      rr_ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  assign pick_start = '0;
`endif

  arb_mux_pick #(.N(NUM_IN), .SW(SEL_W)) u_pick (
    .req_i   (in_valid),
    .start_i (pick_start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Explicit select bypasses the picker; every other mode (including 11) goes through it
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (mode == MODE_SEL) begin
      if (sel_ok && in_valid[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        gnt_any  = 1'b1;
      end
    end else begin
      gnt     = pick_gnt;
      gnt_idx = pick_idx;
      gnt_any = pick_any;
    end
  end

  assign in_ready = rst_n ? (gnt & {NUM_IN{load_en}}) : '0;
  assign xfer     = rst_n && load_en && gnt_any;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    sel_err_d   = (mode == MODE_SEL) && !sel_ok;
    if (load_en) begin
      out_valid_d = gnt_any;
      if (gnt_any) begin
        out_data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_src_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed bench for arb_mux_reg (4-input and 3-input instances)
module tb_arb_mux_reg;

  logic        clk;
  logic        rst_n;

  logic [3:0]   in_valid, in_ready;
  logic [127:0] in_data;
  logic [1:0]   mode, sel;
  logic         out_valid, out_ready, sel_err;
  logic [31:0]  out_data;
  logic [1:0]   out_src;

  logic [2:0]   in_valid3, in_ready3;
  logic [95:0]  in_data3;
  logic [1:0]   mode3, sel3;
  logic         out_valid3, out_ready3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_src3;

  int checks = 0;
  int errors = 0;
  logic [1:0] rr_exp [6];

  arb_mux_reg #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready), .sel_err(sel_err)
  );

  arb_mux_reg #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
    .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_valid(out_valid3),
    .out_data(out_data3), .out_src(out_src3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ARB_MUX_RR_EN
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {32'h33333333, 32'h22222222, 32'h11111111, 32'hA0A0A0A0};
    mode      = 2'b01;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_valid3 = 3'b000;
    in_data3  = {32'h32222222, 32'h31111111, 32'h30000000};
    mode3     = 2'b01;
    sel3      = 2'd0;
    out_ready3 = 1'b1;

    // reset held three cycles with every input requesting
    tick(); tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    chk("rst_sel_err",   64'(sel_err),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);

    rst_n = 1'b1;
    #1;
    chk("first_in_ready", 64'(in_ready), 64'h1);
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data",  64'(out_data),  64'hA0A0A0A0);

    // fixed priority
    in_valid = 4'b1010;
    #1;
    chk("fix_in_ready", 64'(in_ready), 64'h2);
    tick();
    chk("fix_data1", 64'(out_data), 64'h11111111);
    chk("fix_src1",  64'(out_src),  64'd1);
    in_valid = 4'b1000;
    #1;
    chk("fix_in_ready3", 64'(in_ready), 64'h8);
    tick();
    chk("fix_data3", 64'(out_data), 64'h33333333);
    chk("fix_src3",  64'(out_src),  64'd3);

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready),  64'h0);
      tick();
      chk("bp_valid",    64'(out_valid), 64'd1);
      chk("bp_data",     64'(out_data),  64'h33333333);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    chk("bp_refill_data", 64'(out_data), 64'hA0A0A0A0);
    chk("bp_refill_src",  64'(out_src),  64'd0);
    chk("bp_refill_valid", 64'(out_valid), 64'd1);

    // no request: output drops, data holds
    in_valid = 4'b0000;
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_data",  64'(out_data),  64'hA0A0A0A0);

    // explicit select
    mode = 2'b00;
    sel  = 2'd2;
    in_valid = 4'b1011;
    #1;
    chk("sel_in_ready_none", 64'(in_ready), 64'h0);
    tick();
    chk("sel_none_valid", 64'(out_valid), 64'd0);
    chk("sel_err_pow2",   64'(sel_err),   64'd0);
    in_valid = 4'b1111;
    #1;
    chk("sel_in_ready2", 64'(in_ready), 64'h4);
    tick();
    chk("sel_src2",  64'(out_src),  64'd2);
    chk("sel_data2", 64'(out_data), 64'h22222222);

    // round-robin over continuously valid inputs
    mode = 2'b10;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr_src", 64'(out_src), 64'(rr_exp[c]));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end
    mode = 2'b01;
    tick();
    chk("rr_fixed_src", 64'(out_src), 64'd0);
    mode = 2'b10;
    tick();
`ifdef ARB_MUX_RR_EN
    chk("rr_ptr_kept", 64'(out_src), 64'd2);
`else
    chk("rr_ptr_kept", 64'(out_src), 64'd0);
`endif
    mode = 2'b11;
    tick();
    chk("mode11_src", 64'(out_src), 64'd0);

    // reset while output is stalled
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data",  64'(out_data),  64'd0);
    chk("midrst_src",   64'(out_src),   64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // out-of-range select on the 3-input instance
    mode3 = 2'b00;
    sel3  = 2'd3;
    in_valid3 = 3'b111;
    #1;
    chk("sel3_in_ready", 64'(in_ready3), 64'h0);
    tick();
    chk("sel3_err",   64'(sel_err3),   64'd1);
    chk("sel3_valid", 64'(out_valid3), 64'd0);
    sel3 = 2'd1;
    #1;
    chk("sel3_in_ready1", 64'(in_ready3), 64'h2);
    tick();
    chk("sel3_err_clear", 64'(sel_err3),   64'd0);
    chk("sel3_src",       64'(out_src3),   64'd1);
    chk("sel3_data",      64'(out_data3),  64'h31111111);
    chk("sel3_valid1",    64'(out_valid3), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port. It is the next generation of the processor's fixed 4:1 32-bit data mux. Shared datapath resources (write-back port, memory request bus) use it to take one source per cycle. Source choice is by explicit select, fixed priority, or round-robin.

## Interface
- WIDTH, 32, data width per input and output
- NUM_IN, 4, number of inputs; legal range 2..16
- SEL_W (localparam), $clog2(NUM_IN), width of index fields
- Clocking and reset: one clock; reset is synchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  NUM_IN  per-input request
- in_data  in  NUM_IN*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NUM_IN  per-input accept (combinational)
- mode  in  2  00 explicit select, 01 fixed priority, 10 round-robin, 11 treated as 01
- sel  in  SEL_W  source index, used in mode 00 only
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered selected data
- out_src  out  SEL_W  index of the input that supplied out_data
- out_ready  in  1  downstream accept
- sel_err  out  1  registered one-cycle pulse: mode 00 with sel >= NUM_IN

## Operation
- load_en = !out_valid || out_ready. The register can refill in the same cycle it drains.
- Grant selection is combinational from in_valid, mode, sel and rr_ptr. At most one grant per cycle.
  - Mode 00: grant sel if in_valid[sel] is set and sel < NUM_IN; otherwise no grant.
  - Mode 01: grant the lowest-index valid input.
  - Mode 10: grant the first valid input scanning upward from rr_ptr, wrapping from NUM_IN-1 to 0.
- in_ready[i] = grant[i] && load_en. A transfer on input i is in_valid[i] && in_ready[i].
- On a transfer: out_data <= in_data[i], out_src <= i, out_valid <= 1.
- If load_en is set and there is no grant: out_valid <= 0. out_data and out_src hold their values.
- If !load_en: all output registers hold. Inputs must keep valid and data stable until accepted.
- rr_ptr advances only on a transfer made in mode 10: rr_ptr <= (i == NUM_IN-1) ? 0 : i+1. Transfers in other modes leave it unchanged.
- The mode may change on any cycle. It takes effect for that same cycle's grant. rr_ptr is retained across mode changes.
- sel_err <= (mode == 00) && (sel >= NUM_IN), evaluated every cycle regardless of load_en. It is never set when NUM_IN is a power of two.

## Timing
- Reset values: out_valid 0, out_data 0, out_src 0, sel_err 0, rr_ptr 0. in_ready is 0 during reset.
- Latency: input accepted on cycle T, out_valid/out_data visible from cycle T+1.
- Throughput: one transfer per cycle while out_ready stays high.
- Back-pressure: out_valid && !out_ready forces in_ready to all zeros. out_data is stable until accepted.
- Reset asserted mid-transfer discards the held output. No partial state survives.
- The only combinational path is in_valid/mode/sel/out_ready to in_ready. Outputs other than in_ready are registered.

## Configuration
- ARB_MUX_RR_EN defined: round-robin mode and rr_ptr are present, as described above.
- ARB_MUX_RR_EN undefined: no rr_ptr storage. Mode 10 behaves exactly as mode 01. All other behaviour is unchanged.

## Structure
- Package arb_mux_pkg holds:
  - mode constants MODE_SEL = 2'b00, MODE_FIXED = 2'b01, MODE_RR = 2'b10
  - a helper function computing SEL_W
- Sub-module arb_mux_pick: combinational rotating-priority picker. It takes a request vector and a start index, and returns a one-hot grant, the granted index, and an any-grant flag. Mode 01 uses it with start 0; mode 10 with start rr_ptr.
- The top level contains the output register, the rr_ptr register, the sel check and the handshake logic.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid set → out_valid=0, out_data=0, in_ready=0; first transfer happens on the cycle after rst_n rises.
- Fixed priority: NUM_IN=4, mode 01, in_valid=4'b1010, data[1]=0x11111111, data[3]=0x33333333, out_ready=1 → next cycle out_data=0x11111111, out_src=1; input 3 is accepted one cycle after input 1 deasserts.
- Round-robin fairness: mode 10, all four inputs continuously valid, out_ready=1 → out_src sequence 0,1,2,3,0,1 on consecutive cycles.
- Back-pressure: out_valid=1, out_ready=0 for 5 cycles → in_ready=0, out_data stable. Raising out_ready for one cycle drains and refills in the same cycle.
- Explicit select: mode 00, sel=2, in_valid[2]=0 then 1 → no transfer and out_valid falls; then out_src=2. With NUM_IN=3, sel=3 → sel_err pulses 1 and nothing is granted.
- Macro off: ARB_MUX_RR_EN undefined, mode 10, all inputs valid → out_src stays 0 on every cycle.
